// File: rtl/input_port_reorder.sv
// Leaf input port with a bank-interleaved reorder buffer: filters packets by port and delivers payloads in address order.
// Optional drop counter is built only when INPUT_PORT_DROP_CNT_EN is defined.
module input_port_reorder #(
    parameter int PACKET_BITS           = 97,
    parameter int NUM_LEAF_BITS         = 6,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int PAYLOAD_BITS          = 64,
    parameter int NUM_BANKS             = 2,
    parameter int PORT_No               = 2,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PACKET_BITS-1:0]     din_leaf_bft2interface,
    input  logic [NUM_LEAF_BITS-1:0]   src_leaf,
    input  logic [NUM_PORT_BITS-1:0]   src_port,
    output logic                       freespace_update,
    output logic [PACKET_BITS-1:0]     packet_from_input_port,
    output logic [PAYLOAD_BITS-1:0]    dout2user,
    output logic                       vld2user,
    input  logic                       ack_user2b_in,
    output logic [NUM_ADDR_BITS:0]     occupancy,
    output logic                       overflow_err,
    output logic [15:0]                drop_cnt
);

    localparam int DEPTH     = 1 << NUM_ADDR_BITS;
    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int BANK_W    = (NUM_BANKS > 1) ? BANK_BITS : 1;
    localparam int ROWS      = DEPTH / NUM_BANKS;
    localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CNT_W     = NUM_ADDR_BITS + 1;
    localparam int ZERO_W    = PACKET_BITS - 1 - NUM_LEAF_BITS - NUM_PORT_BITS - PAYLOAD_BITS;

    function automatic logic [BANK_W-1:0] bank_of(input logic [NUM_ADDR_BITS-1:0] a);
        logic [NUM_ADDR_BITS-1:0] m;
        m = a & NUM_ADDR_BITS'(NUM_BANKS - 1);
        return BANK_W'(m);
    endfunction

    function automatic logic [ROW_W-1:0] row_of(input logic [NUM_ADDR_BITS-1:0] a);
        return ROW_W'(a >> BANK_BITS);
    endfunction

    logic                      pkt_valid_s;
    logic [NUM_PORT_BITS-1:0]  pkt_port_s;
    logic [NUM_ADDR_BITS-1:0]  pkt_addr_s;
    logic [PAYLOAD_BITS-1:0]   pkt_payload_s;
    logic                      accept_s;
    logic                      hit_s;
    logic                      wr_en_s;
    logic                      drop_s;
    logic                      load_s;
    logic                      consume_s;
    logic [BANK_W-1:0]         wr_bank_s;
    logic [ROW_W-1:0]          wr_row_s;
    logic [BANK_W-1:0]         rd_bank_s;
    logic [ROW_W-1:0]          rd_row_s;
    logic [PAYLOAD_BITS-1:0]   bank_rd_s [NUM_BANKS];
    logic [PAYLOAD_BITS-1:0]   rd_data_s;
    logic [PACKET_BITS-1:0]    credit_pkt_s;
    logic                      unused_s;

    logic [DEPTH-1:0]          valid_q, valid_d;
    logic [NUM_ADDR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
    logic                      vld_q, vld_d;
    logic [PAYLOAD_BITS-1:0]   dout_q, dout_d;
    logic [CNT_W-1:0]          occ_q, occ_d;
    logic                      ovf_q, ovf_d;
    logic [CNT_W-1:0]          cons_q, cons_d;
    logic                      fs_q, fs_d;
    logic [PACKET_BITS-1:0]    cpkt_q, cpkt_d;

    assign pkt_valid_s   = din_leaf_bft2interface[PACKET_BITS-1];
    assign pkt_port_s    = din_leaf_bft2interface[PACKET_BITS-2-NUM_LEAF_BITS -: NUM_PORT_BITS];
    assign pkt_addr_s    = din_leaf_bft2interface[PAYLOAD_BITS +: NUM_ADDR_BITS];
    assign pkt_payload_s = din_leaf_bft2interface[PAYLOAD_BITS-1:0];
    assign unused_s      = ^din_leaf_bft2interface;

    // A write into an occupied slot is an overflow: the new data is dropped, the old slot survives.
    assign accept_s  = pkt_valid_s && (pkt_port_s == NUM_PORT_BITS'(PORT_No));
    assign hit_s     = valid_q[pkt_addr_s];
    assign wr_en_s   = accept_s && !hit_s;
    assign drop_s    = accept_s && hit_s;
    assign load_s    = valid_q[rd_ptr_q] && (!vld_q || ack_user2b_in);
    assign consume_s = vld_q && ack_user2b_in;

    assign wr_bank_s = bank_of(pkt_addr_s);
    assign wr_row_s  = row_of(pkt_addr_s);
    assign rd_bank_s = bank_of(rd_ptr_q);
    assign rd_row_s  = row_of(rd_ptr_q);
    assign rd_data_s = bank_rd_s[rd_bank_s];

    assign credit_pkt_s = {1'b1, src_leaf, src_port, {ZERO_W{1'b0}},
                           PAYLOAD_BITS'(FREESPACE_UPDATE_SIZE)};

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [PAYLOAD_BITS-1:0] mem_q [ROWS];
        logic                    bank_we_s;

        assign bank_we_s = wr_en_s && (wr_bank_s == BANK_W'(b));

        // Payload storage needs no reset; the slot valid bits gate every read.
        always_ff @(posedge clk) begin
            if (bank_we_s) begin
                mem_q[wr_row_s] <= pkt_payload_s;
            end
        end

        assign bank_rd_s[b] = mem_q[rd_row_s];
    end

    // Slot valid bits: set on accepted write, cleared when the slot moves to the output register.
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            valid_d[i] = (valid_q[i] | (wr_en_s && (pkt_addr_s == NUM_ADDR_BITS'(i))))
                       & ~(load_s && (rd_ptr_q == NUM_ADDR_BITS'(i)));
        end
    end

    // Read pointer, occupancy, output register and sticky overflow.
    always_comb begin
        rd_ptr_d = load_s ? (rd_ptr_q + NUM_ADDR_BITS'(1)) : rd_ptr_q;
        ovf_d    = ovf_q | drop_s;
        case ({wr_en_s, load_s})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase
        if (load_s) begin
            vld_d  = 1'b1;
            dout_d = rd_data_s;
        end else if (consume_s) begin
            vld_d  = 1'b0;
            dout_d = dout_q;
        end else begin
            vld_d  = vld_q;
            dout_d = dout_q;
        end
    end

    // Credit return: one pulse carrying a fresh credit packet per FREESPACE_UPDATE_SIZE consumed words.
    always_comb begin
        if (consume_s) begin
            if (cons_q == CNT_W'(FREESPACE_UPDATE_SIZE - 1)) begin
                cons_d = '0;
                fs_d   = 1'b1;
                cpkt_d = credit_pkt_s;
            end else begin
                cons_d = cons_q + CNT_W'(1);
                fs_d   = 1'b0;
                cpkt_d = '0;
            end
        end else begin
            cons_d = cons_q;
            fs_d   = 1'b0;
            cpkt_d = '0;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= '0;
            rd_ptr_q <= '0;
            vld_q    <= 1'b0;
            dout_q   <= '0;
            occ_q    <= '0;
            ovf_q    <= 1'b0;
            cons_q   <= '0;
            fs_q     <= 1'b0;
            cpkt_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            rd_ptr_q <= rd_ptr_d;
            vld_q    <= vld_d;
            dout_q   <= dout_d;
            occ_q    <= occ_d;
            ovf_q    <= ovf_d;
            cons_q   <= cons_d;
            fs_q     <= fs_d;
            cpkt_q   <= cpkt_d;
        end
    end

`ifdef INPUT_PORT_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of dropped overflow packets.
    always_comb begin
        if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= 16'h0000;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 16'h0000;
`endif

    assign vld2user               = vld_q;
    assign dout2user              = dout_q;
    assign occupancy              = occ_q;
    assign overflow_err           = ovf_q;
    assign freespace_update       = fs_q;
    assign packet_from_input_port = cpkt_q;

endmodule

// File: tb/tb_input_port_reorder.sv
// Scoreboard bench for input_port_reorder: expected payloads queued at drive time, popped on each handshake.
module tb_input_port_reorder;

    logic        clk;
    logic        reset;
    logic [96:0] din;
    logic [5:0]  src_leaf;
    logic [3:0]  src_port;
    logic        freespace_update;
    logic [96:0] packet_from_input_port;
    logic [63:0] dout2user;
    logic        vld2user;
    logic        ack;
    logic [7:0]  occupancy;
    logic        overflow_err;
    logic [15:0] drop_cnt;

    int          checks;
    int          errors;
    int          pulse_cnt;
    logic [63:0] exp_q [$];
    logic [96:0] exp_credit;
    logic [15:0] exp_drop;

    input_port_reorder dut (
        .clk                    (clk),
        .reset                  (reset),
        .din_leaf_bft2interface (din),
        .src_leaf               (src_leaf),
        .src_port               (src_port),
        .freespace_update       (freespace_update),
        .packet_from_input_port (packet_from_input_port),
        .dout2user              (dout2user),
        .vld2user               (vld2user),
        .ack_user2b_in          (ack),
        .occupancy              (occupancy),
        .overflow_err           (overflow_err),
        .drop_cnt               (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [96:0] mk_pkt(input logic [3:0] port, input logic [6:0] addr,
                                           input logic [63:0] pl);
        return {1'b1, 6'h00, port, 15'h0000, addr, pl};
    endfunction

    // Monitor: scoreboard pop on every handshake, credit packet check every cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (vld2user && ack) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output got %h required none", dout2user);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    if (dout2user !== e) begin
                        errors++;
                        $display("FAIL dout2user got %h required %h", dout2user, e);
                    end
                end
            end
            checks++;
            if (freespace_update) begin
                pulse_cnt++;
                if (packet_from_input_port !== exp_credit) begin
                    errors++;
                    $display("FAIL credit_pkt got %h required %h", packet_from_input_port, exp_credit);
                end
            end else if (packet_from_input_port !== 97'd0) begin
                errors++;
                $display("FAIL credit_idle got %h required 0", packet_from_input_port);
            end
        end
    end

    task automatic reset_dut();
        reset = 1'b1;
        din   = '0;
        ack   = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !vld2user) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        din   = '0;
        ack   = 1'b0;
        #7;
        checks++; if (vld2user !== 1'b0) begin errors++; $display("FAIL rst_vld got %b required 0", vld2user); end
        checks++; if (dout2user !== 64'd0) begin errors++; $display("FAIL rst_dout got %h required 0", dout2user); end
        checks++; if (occupancy !== 8'd0) begin errors++; $display("FAIL rst_occ got %0d required 0", occupancy); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b required 0", overflow_err); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rst_drop got %0d required 0", drop_cnt); end
        checks++; if (freespace_update !== 1'b0) begin errors++; $display("FAIL rst_fs got %b required 0", freespace_update); end
        checks++; if (packet_from_input_port !== 97'd0) begin errors++; $display("FAIL rst_pkt got %h required 0", packet_from_input_port); end
        reset_dut();
    endtask

    task automatic test_in_order();
        bit ok;
        reset_dut();
        ack = 1'b1;
        for (int i = 0; i < 6; i++) exp_q.push_back(64'hA0 + 64'(i));
        din = mk_pkt(4'd2, 7'd0, 64'hA0);
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk);
            #1;
            din = (c <= 5) ? mk_pkt(4'd2, 7'(c), 64'hA0 + 64'(c)) : 97'd0;
            checks++;
            if (vld2user !== (c >= 2)) begin
                errors++;
                $display("FAIL inorder_vld cycle %0d got %b required %b", c, vld2user, (c >= 2));
            end
        end
        wait_drain(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL inorder_drain got left %0d required 0", exp_q.size()); end
    endtask

    task automatic test_reorder();
        bit ok;
        reset_dut();
        ack = 1'b1;
        exp_q.push_back(64'h00); exp_q.push_back(64'h11); exp_q.push_back(64'h22);
        din = mk_pkt(4'd2, 7'd2, 64'h22);
        @(posedge clk); #1;
        din = mk_pkt(4'd2, 7'd1, 64'h11);
        checks++; if (vld2user !== 1'b0) begin errors++; $display("FAIL reorder_wait1 got %b required 0", vld2user); end
        @(posedge clk); #1;
        din = '0;
        checks++; if (occupancy !== 8'd2) begin errors++; $display("FAIL reorder_occ2 got %0d required 2", occupancy); end
        checks++; if (vld2user !== 1'b0) begin errors++; $display("FAIL reorder_wait2 got %b required 0", vld2user); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        din = mk_pkt(4'd2, 7'd0, 64'h00);
        @(posedge clk); #1;
        din = '0;
        checks++; if (occupancy !== 8'd3) begin errors++; $display("FAIL reorder_occ3 got %0d required 3", occupancy); end
        checks++; if (vld2user !== 1'b0) begin errors++; $display("FAIL reorder_nobypass got %b required 0", vld2user); end
        wait_drain(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL reorder_drain got left %0d required 0", exp_q.size()); end
    endtask

    task automatic test_filter_backpressure();
        bit ok;
        reset_dut();
        ack = 1'b0;
        din = mk_pkt(4'd5, 7'd0, 64'hBAD);
        repeat (4) begin @(posedge clk); #1; din = '0; end
        checks++; if ({vld2user, occupancy} !== 9'd0) begin errors++; $display("FAIL filter got vld %b occ %0d required 0 0", vld2user, occupancy); end
        exp_q.push_back(64'h55); exp_q.push_back(64'h66);
        din = mk_pkt(4'd2, 7'd0, 64'h55);
        @(posedge clk); #1;
        din = mk_pkt(4'd2, 7'd1, 64'h66);
        @(posedge clk); #1;
        din = '0;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({vld2user, dout2user, occupancy} !== {1'b1, 64'h55, 8'd1}) begin
                errors++;
                $display("FAIL backpressure cycle %0d got vld %b dout %h occ %0d required 1 55 1", c, vld2user, dout2user, occupancy);
            end
            @(posedge clk); #1;
        end
        ack = 1'b1;
        wait_drain(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_drain got left %0d required 0", exp_q.size()); end
    endtask

    task automatic test_wrap_credit();
        bit ok;
        logic [63:0] pl;
        reset_dut();
        ack = 1'b1;
        pulse_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            pl = {$urandom, $urandom};
            exp_q.push_back(pl);
            din = mk_pkt(4'd2, 7'(i), pl);
            @(posedge clk); #1;
        end
        din = '0;
        wait_drain(40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_drain got left %0d required 0", exp_q.size()); end
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (pulse_cnt != 3) begin errors++; $display("FAIL credit_count got %0d required 3", pulse_cnt); end
        checks++; if (occupancy !== 8'd0) begin errors++; $display("FAIL wrap_occ got %0d required 0", occupancy); end
    endtask

    task automatic test_overflow();
        bit ok;
        reset_dut();
        ack = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back(64'h0B00 + 64'(i));
        exp_q.push_back(64'h1111);
        din = mk_pkt(4'd2, 7'd5, 64'h1111);
        @(posedge clk); #1;
        din = mk_pkt(4'd2, 7'd5, 64'h2222);
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_early got %b required 0", overflow_err); end
        @(posedge clk); #1;
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_set got %b required 1", overflow_err); end
        checks++; if (occupancy !== 8'd1) begin errors++; $display("FAIL ovf_occ got %0d required 1", occupancy); end
        for (int i = 0; i < 5; i++) begin
            din = mk_pkt(4'd2, 7'(i), 64'h0B00 + 64'(i));
            @(posedge clk); #1;
        end
        din = '0;
        wait_drain(30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_drain got left %0d required 0", exp_q.size()); end
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b required 1", overflow_err); end
        checks++; if (drop_cnt !== exp_drop) begin errors++; $display("FAIL drop_cnt got %0d required %0d", drop_cnt, exp_drop); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        reset_dut();
        ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din = mk_pkt(4'd2, 7'(i), 64'hC0 + 64'(i));
            @(posedge clk); #1;
        end
        din = '0;
        checks++; if ({vld2user, occupancy} !== {1'b1, 8'd4}) begin errors++; $display("FAIL mid_pre got vld %b occ %0d required 1 4", vld2user, occupancy); end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({vld2user, dout2user, occupancy, overflow_err, freespace_update} !== 75'd0) begin
            errors++;
            $display("FAIL mid_reset got vld %b dout %h occ %0d ovf %b required all 0", vld2user, dout2user, occupancy, overflow_err);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        ack = 1'b1;
        exp_q.push_back(64'h77);
        din = mk_pkt(4'd2, 7'd0, 64'h77);
        @(posedge clk); #1;
        din = '0;
        wait_drain(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_after got left %0d required 0", exp_q.size()); end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        pulse_cnt  = 0;
        src_leaf   = 6'h2A;
        src_port   = 4'h3;
        exp_credit = {1'b1, 6'h2A, 4'h3, 22'd0, 64'd64};
`ifdef INPUT_PORT_DROP_CNT_EN
        exp_drop   = 16'd1;
`else
        exp_drop   = 16'd0;
`endif
        test_reset();
        test_in_order();
        test_reorder();
        test_filter_backpressure();
        test_wrap_credit();
        test_overflow();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout got running required finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/input_port_reorder.md
Name: input_port_reorder

Overview:
Single-clock, parametrised successor to the BFT leaf input port. It accepts packets from the leaf interface, filters them by destination port, and stores each payload in an NUM_ADDR_BITS-addressed reorder buffer interleaved across NUM_BANKS banks. It delivers payloads to the user strictly in sequence-address order over a valid/ack handshake. It returns freespace credit packets to the BFT every FREESPACE_UPDATE_SIZE consumed words, and flags protocol overflow.

Parameters:
PACKET_BITS, 97, total BFT packet width
NUM_LEAF_BITS, 6, leaf id field width
NUM_PORT_BITS, 4, port id field width
NUM_ADDR_BITS, 7, sequence address width; buffer depth 2**NUM_ADDR_BITS
PAYLOAD_BITS, 64, payload width
NUM_BANKS, 2, power of 2, ≤ 2**NUM_ADDR_BITS; bank = addr[log2(NUM_BANKS)-1:0]
PORT_No, 2, port id this instance accepts
FREESPACE_UPDATE_SIZE, 64, consumed words per credit packet; 1..2**NUM_ADDR_BITS

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-high
din_leaf_bft2interface  in  PACKET_BITS  incoming packet; bit PACKET_BITS-1 = valid
src_leaf  in  NUM_LEAF_BITS  own leaf id for credit packets
src_port  in  NUM_PORT_BITS  own port id for credit packets
freespace_update  out  1  one-cycle credit pulse
packet_from_input_port  out  PACKET_BITS  credit packet; all zero when no pulse
dout2user  out  PAYLOAD_BITS  in-order payload
vld2user  out  1  dout2user valid
ack_user2b_in  in  1  user accepts while vld2user=1
occupancy  out  NUM_ADDR_BITS+1  count of valid slots
overflow_err  out  1  sticky protocol error
drop_cnt  out  16  dropped-packet count (feature-dependent)

Behaviour:
- Packet fields: valid=[PACKET_BITS-1]; port=[PACKET_BITS-2-NUM_LEAF_BITS -: NUM_PORT_BITS]; addr=[PAYLOAD_BITS+NUM_ADDR_BITS-1:PAYLOAD_BITS]; payload=[PAYLOAD_BITS-1:0].
- Accept: valid=1 and port==PORT_No. Write payload to slot[addr] and set slot valid bit at the clock edge.
- Accepted write to an already-valid slot: drop the data, keep the old slot contents, set overflow_err (cleared only by reset), and increment drop_cnt.
- Read: rd_ptr starts at 0.
  - Output register loads when slot[rd_ptr] is valid and (vld2user==0 or ack_user2b_in==1).
  - On load: clear the slot valid bit and increment rd_ptr modulo 2**NUM_ADDR_BITS, wrapping 2**NUM_ADDR_BITS-1 to 0.
- Latency: write at edge N makes the slot valid; vld2user asserts after edge N+1 (2 cycles from packet to vld) if the output register is free. With continuous ack, throughput is 1 word/cycle.
- vld2user and dout2user stay stable until acked.
- Out-of-order arrival: a slot ahead of rd_ptr waits. No output appears until slot[rd_ptr] fills.
- Same-cycle write to slot[rd_ptr] while it is invalid: the load sees the slot on the next cycle. There is no bypass.
- Same-cycle write and read-clear on one slot cannot occur, because a read requires a valid slot and a write to a valid slot is an overflow. Overflow takes priority and the slot is cleared by the read.
- occupancy = valid slots, excluding the output register. It updates each cycle (+1 accept, -1 load, net 0 on both).
- Credit: cons_cnt increments on vld2user & ack_user2b_in.
  - When the increment reaches FREESPACE_UPDATE_SIZE: cons_cnt returns to 0 and freespace_update pulses high for exactly the next cycle.
  - Credit packet: packet_from_input_port = {1'b1, src_leaf, src_port, zeros, update} with update = FREESPACE_UPDATE_SIZE zero-extended to PAYLOAD_BITS.
  - No backpressure on credit packets.
- Reset (async, any time): all slot valid bits, rd_ptr, cons_cnt, vld2user, dout2user, freespace_update, packet_from_input_port, occupancy, overflow_err and drop_cnt go to 0. Mid-operation data is discarded.

Optional Feature:
INPUT_PORT_DROP_CNT_EN
- Defined: drop_cnt counts dropped packets, saturating at 16'hFFFF.
- Undefined: drop_cnt is tied to 0 and no counter logic is built. overflow_err is unaffected either way.

Test Plan:
- In-order: addr 0..5 to PORT_No with payloads 0xA0..0xA5, ack held high -> dout2user 0xA0..0xA5 on consecutive cycles, first vld2user 2 cycles after the first packet.
- Reorder: addr 2,1,0 with payloads 0x22,0x11,0x00 -> no vld2user until addr 0 arrives, then 0x00, 0x11, 0x22 in order; occupancy peaks at 3.
- Filter/backpressure: a packet with port≠PORT_No is ignored. With ack low for 10 cycles after vld2user, dout2user stays constant and occupancy does not drop for that word.
- Wrap/credit: with NUM_ADDR_BITS=7 and FREESPACE_UPDATE_SIZE=64, stream 200 words in order -> addr 127→0 wraps seamlessly; exactly 3 freespace_update pulses, each with packet low field = 64 and top bit 1.
- Overflow: write addr 5 twice before it is read -> overflow_err=1, first payload delivered, drop_cnt=1 (0 without INPUT_PORT_DROP_CNT_EN).
- Reset mid-stream: assert reset with 4 slots valid and vld2user=1 -> all outputs 0 immediately. After release, addr 0 is delivered normally.
